// File: rtl/lc3b_types.sv
// ============================================================================
// Module   : lc3b_types
// Brief    : Shared cache types and line-fill FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lc3b_types;

    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 16;

    typedef logic [2:0]                     lc3b_cache_offset;
    typedef logic [LINE_WORDS*WORD_W-1:0]   lc3b_cache_size;
    typedef logic [WORD_W-1:0]              lc3b_word;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } lfb_state_e;

    // The beat pointer walks the line circularly, so 7 wraps back to 0.
    function automatic lc3b_cache_offset next_offset(input lc3b_cache_offset off);
        return off + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_word_writer.sv
// ============================================================================
// Module   : line_word_writer
// Brief    : 8x16 word store with indexed write, flattened as a cache line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_word_writer
    import lc3b_types::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  lc3b_cache_offset idx,
    input  lc3b_word         wdata,
    output lc3b_cache_size   line
);

    lc3b_word r_words [LINE_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_words[i] <= '0;
            end
        end else if (we) begin
            r_words[idx] <= wdata;
        end
    end

    // Word i occupies bits [16i+15:16i] to line up with the downstream selector.
    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
        assign line[g*WORD_W +: WORD_W] = r_words[g];
    end

endmodule

`default_nettype wire

// File: rtl/line_fill_buffer.sv
// ============================================================================
// Module   : line_fill_buffer
// Brief    : Critical-word-first 8-beat line fill from a 16-bit memory port.
//            Optional macro FILL_CRIT_FWD_EN enables critical-word forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_fill_buffer
    import lc3b_types::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  lc3b_cache_offset req_offset,
    output logic             mem_read,
    output lc3b_cache_offset beat_offset,
    input  logic             mem_resp,
    input  lc3b_word         mem_rdata,
    output lc3b_cache_size   line_out,
    output logic             line_valid,
    input  logic             line_ack,
    output logic             busy,
    output logic             crit_valid,
    output lc3b_word         crit_word
);

    lfb_state_e       r_state;
    lc3b_cache_offset r_ptr;
    logic [2:0]       r_cnt;
    logic             w_wr_en;

    assign w_wr_en     = (r_state == ST_FILL) && mem_resp;
    assign beat_offset = r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            mem_read   <= 1'b0;
            line_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_state  <= ST_FILL;
                        r_ptr    <= req_offset;
                        r_cnt    <= '0;
                        mem_read <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (mem_resp) begin
                        r_ptr <= next_offset(r_ptr);
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state    <= ST_DONE;
                            mem_read   <= 1'b0;
                            line_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // A simultaneous req is dropped; the consumer must re-request from IDLE.
                    if (line_ack) begin
                        r_state    <= ST_IDLE;
                        line_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    mem_read   <= 1'b0;
                    line_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef FILL_CRIT_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crit_valid <= 1'b0;
            crit_word  <= '0;
        end else if (w_wr_en && (r_cnt == 3'd0)) begin
            crit_valid <= 1'b1;
            crit_word  <= mem_rdata;
        end else begin
            crit_valid <= 1'b0;
        end
    end
`else
    assign crit_valid = 1'b0;
    assign crit_word  = '0;
`endif

    line_word_writer u_line_word_writer (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr_en),
        .idx   (r_ptr),
        .wdata (mem_rdata),
        .line  (line_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_line_fill_buffer.sv
// ============================================================================
// Module   : tb_line_fill_buffer
// Brief    : Directed self-checking bench for line_fill_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_line_fill_buffer;
    import lc3b_types::*;

    logic             clk;
    logic             rst_n;
    logic             req;
    lc3b_cache_offset req_offset;
    logic             mem_read;
    lc3b_cache_offset beat_offset;
    logic             mem_resp;
    lc3b_word         mem_rdata;
    lc3b_cache_size   line_out;
    logic             line_valid;
    logic             line_ack;
    logic             busy;
    logic             crit_valid;
    lc3b_word         crit_word;

    int vectors;
    int miscompares;

    logic [15:0]  beats [8];
    int           gaps  [8];
    logic [2:0]   seen_off [8];
    int           mr_low;
    int           crit_pulses;
    logic [15:0]  crit_seen;
    logic         lv_after;
    int           lv_early;
    logic [127:0] exp_line;

    line_fill_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_offset  (req_offset),
        .mem_read    (mem_read),
        .beat_offset (beat_offset),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .line_out    (line_out),
        .line_valid  (line_valid),
        .line_ack    (line_ack),
        .busy        (busy),
        .crit_valid  (crit_valid),
        .crit_word   (crit_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus driver: issues a request and feeds eight beats with optional gaps.
    task automatic run_fill(input logic [2:0] off);
        @(negedge clk);
        req = 1'b1; req_offset = off;
        @(negedge clk);
        req = 1'b0;
        mr_low = 0; crit_pulses = 0; crit_seen = '0; lv_early = 0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                if (!mem_read) mr_low++;
                @(negedge clk);
                if (crit_valid) begin crit_pulses++; crit_seen = crit_word; end
                if (line_valid) lv_early++;
            end
            seen_off[i] = beat_offset;
            if (!mem_read) mr_low++;
            if (i > 0 && line_valid) lv_early++;
            mem_resp = 1'b1; mem_rdata = beats[i];
            @(negedge clk);
            mem_resp = 1'b0;
            if (crit_valid) begin crit_pulses++; crit_seen = crit_word; end
        end
        lv_after = line_valid;
    endtask

    task automatic model_line(input logic [2:0] off);
        exp_line = '0;
        for (int i = 0; i < 8; i++) begin
            exp_line[16*((int'(off)+i)%8) +: 16] = beats[i];
        end
    endtask

    task automatic ack_line();
        @(negedge clk);
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if ({mem_read, busy, line_valid, crit_valid} !== 4'b0) begin
            miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {mem_read, busy, line_valid, crit_valid}); end
        vectors++; if (line_out !== 128'h0) begin
            miscompares++; $display("FAIL reset_line: got %h want 0", line_out); end
        vectors++; if (beat_offset !== 3'd0 || crit_word !== 16'h0) begin
            miscompares++; $display("FAIL reset_off_crit: got off=%0d crit=%h want 0/0", beat_offset, crit_word); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [2:0] exp_off [8];
        for (int i = 0; i < 8; i++) begin
            beats[i] = 16'h1111 * 16'(i + 1); gaps[i] = 0;
            exp_off[i] = 3'((3 + i) % 8);
        end
        run_fill(3'd3);
        model_line(3'd3);
        for (int i = 0; i < 8; i++) begin
            vectors++; if (seen_off[i] !== exp_off[i]) begin
                miscompares++; $display("FAIL basic_beat_offset[%0d]: got %0d want %0d", i, seen_off[i], exp_off[i]); end
        end
        vectors++; if (line_out[63:48] !== 16'h1111 || line_out[47:32] !== 16'h8888) begin
            miscompares++; $display("FAIL basic_w3_w2: got %h/%h want 1111/8888", line_out[63:48], line_out[47:32]); end
        vectors++; if (line_out !== exp_line) begin
            miscompares++; $display("FAIL basic_line: got %h want %h", line_out, exp_line); end
        vectors++; if (lv_after !== 1'b1 || lv_early != 0) begin
            miscompares++; $display("FAIL basic_line_valid: got after=%b early=%0d want 1/0", lv_after, lv_early); end
        vectors++; if (mem_read !== 1'b0 || busy !== 1'b1 || mr_low != 0) begin
            miscompares++; $display("FAIL basic_done_ctrl: got mr=%b busy=%b mrlow=%0d want 0/1/0", mem_read, busy, mr_low); end
        ack_line();
        vectors++; if (busy !== 1'b0 || line_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_ack_idle: got busy=%b lv=%b want 0/0", busy, line_valid); end
    endtask

    task automatic test_crit_fwd();
        beats[0] = 16'hBEEF;
        for (int i = 1; i < 8; i++) begin beats[i] = 16'hC000 + 16'(i); gaps[i] = 0; end
        gaps[0] = 1;
        run_fill(3'd5);
`ifdef FILL_CRIT_FWD_EN
        vectors++; if (crit_pulses != 1 || crit_seen !== 16'hBEEF) begin
            miscompares++; $display("FAIL crit_fwd: got pulses=%0d word=%h want 1/beef", crit_pulses, crit_seen); end
`else
        vectors++; if (crit_pulses != 0 || crit_word !== 16'h0) begin
            miscompares++; $display("FAIL crit_off: got pulses=%0d word=%h want 0/0", crit_pulses, crit_word); end
`endif
        model_line(3'd5);
        vectors++; if (line_out[95:80] !== 16'hBEEF || line_out !== exp_line) begin
            miscompares++; $display("FAIL crit_line: got %h want %h", line_out, exp_line); end
        ack_line();
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 8; i++) begin
            beats[i] = 16'hA5A0 ^ 16'(i * 16'h0111); gaps[i] = i % 4;
        end
        run_fill(3'd6);
        model_line(3'd6);
        vectors++; if (line_out !== exp_line) begin
            miscompares++; $display("FAIL gaps_line: got %h want %h", line_out, exp_line); end
        vectors++; if (mr_low != 0 || lv_after !== 1'b1) begin
            miscompares++; $display("FAIL gaps_mem_read: got low=%0d lv=%b want 0/1", mr_low, lv_after); end
    endtask

    task automatic test_done_hold();
        logic [127:0] held;
        int bad;
        held = line_out; bad = 0;
        for (int c = 0; c < 10; c++) begin
            req = c[0]; req_offset = 3'd1;
            @(negedge clk);
            if (line_valid !== 1'b1 || line_out !== held || mem_read !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin
            miscompares++; $display("FAIL done_hold: got %0d unstable cycles want 0", bad); end
        req = 1'b1; line_ack = 1'b1;
        @(negedge clk);
        req = 1'b0; line_ack = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || mem_read !== 1'b0 || line_valid !== 1'b0) begin
            miscompares++; $display("FAIL done_ack_req: got busy=%b mr=%b lv=%b want 0/0/0", busy, mem_read, line_valid); end
        vectors++; if (line_out !== held) begin
            miscompares++; $display("FAIL idle_retain: got %h want %h", line_out, held); end
    endtask

    task automatic test_ignored();
        logic [127:0] held;
        held = line_out;
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 16'hDEAD; line_ack = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0; line_ack = 1'b0;
        @(negedge clk);
        vectors++; if (line_out !== held || busy !== 1'b0) begin
            miscompares++; $display("FAIL idle_ignore: got busy=%b line=%h want 0/%h", busy, line_out, held); end
    endtask

    task automatic test_reset_midfill();
        @(negedge clk);
        req = 1'b1; req_offset = 3'd2;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp = 1'b1; mem_rdata = 16'h5500 + 16'(i);
            @(negedge clk);
        end
        mem_resp = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (mem_read !== 1'b0 || busy !== 1'b0 || line_out !== 128'h0 || line_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_midfill: got mr=%b busy=%b lv=%b line=%h want 0/0/0/0", mem_read, busy, line_valid, line_out); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (line_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_no_valid: got lv=%b busy=%b want 0/0", line_valid, busy); end
        for (int i = 0; i < 8; i++) begin beats[i] = 16'h0F00 + 16'(i * 3); gaps[i] = 0; end
        run_fill(3'd1);
        model_line(3'd1);
        vectors++; if (line_out !== exp_line || lv_after !== 1'b1) begin
            miscompares++; $display("FAIL refill_line: got %h want %h", line_out, exp_line); end
        ack_line();
    endtask

    task automatic test_offset0();
        int bad;
        for (int i = 0; i < 8; i++) begin beats[i] = 16'h1230 + 16'(i); gaps[i] = 0; end
        run_fill(3'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) if (seen_off[i] !== 3'(i)) bad++;
        vectors++; if (bad != 0) begin
            miscompares++; $display("FAIL off0_sequence: got %0d wrong offsets want 0", bad); end
        vectors++; if (line_out !== {beats[7], beats[6], beats[5], beats[4], beats[3], beats[2], beats[1], beats[0]}) begin
            miscompares++; $display("FAIL off0_line: got %h", line_out); end
        ack_line();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; req = 1'b0; req_offset = '0;
        mem_resp = 1'b0; mem_rdata = '0; line_ack = 1'b0;
        test_reset();
        test_basic();
        test_crit_fwd();
        test_gaps();
        test_done_hold();
        test_ignored();
        test_reset_midfill();
        test_offset0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
